bus_mem_responder: RTL and testbench
====================================

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, number of 32-bit words; SHALL be a power of two.
REQ-002 Parameter LATENCY, default 1, cycles from request acceptance to bus_done; SHALL be 1..15.
REQ-003 Parameter INIT_FILE, default "", hex image loaded at elaboration when non-empty.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 bus_addr  input  32  byte address; word index = bus_addr[31:2].
REQ-007 bus_wdata  input  32  lane-aligned write data.
REQ-008 bus_wmask  input  4  byte-lane write enables; bit n covers wdata[8n+7:8n].
REQ-009 bus_wen  input  1  write request level, held by initiator until bus_done.
REQ-010 bus_ren  input  1  read request level, held by initiator until bus_done.
REQ-011 bus_rdata  output  32  read data, full aligned word.
REQ-012 bus_done  output  1  one-cycle completion pulse for the accepted request.
REQ-013 bus_err  output  1  one-cycle pulse coincident with bus_done when word index >= DEPTH_WORDS.

Function
REQ-014 FSM states IDLE, BUSY, DONE; encoded one-hot.
REQ-015 IDLE: bus_wen|bus_ren high at a rising edge -> request accepted; addr, wdata, wmask, direction latched at that edge.
REQ-016 Accept transition: LATENCY=1 -> DONE; LATENCY>1 -> BUSY with down-counter loaded LATENCY-2.
REQ-017 BUSY: counter decrements each cycle; at zero -> DONE; total accept-to-done = LATENCY cycles.
REQ-018 DONE: bus_done=1 for exactly this cycle; next state always IDLE; request inputs during DONE ignored.
REQ-019 Request still high in IDLE after DONE is a new request (back-to-back: one idle cycle minimum between done pulses).
REQ-020 bus_wen and bus_ren both high at acceptance: write performed, read ignored, bus_rdata unchanged.
REQ-021 Write: on edge entering DONE, each lane with latched wmask bit set updated; unmasked lanes preserved; wmask=0 completes with no change.
REQ-022 Read: on edge entering DONE, bus_rdata loaded with addressed word; bus_rdata holds until next completed read.
REQ-023 Out-of-range index: write suppressed, read returns 32'h0, bus_done and bus_err both pulse.
REQ-024 Inputs changing after acceptance have no effect on the in-flight request.
REQ-025 bus_done, bus_err, bus_rdata are registered outputs; no combinational input-to-output path.

Reset
REQ-026 rst at a rising edge: state -> IDLE, counter -> 0, bus_done -> 0, bus_err -> 0, bus_rdata -> 32'h0.
REQ-027 rst during BUSY aborts the request; no memory write; no bus_done pulse.
REQ-028 rst has priority over acceptance and over entry to DONE in the same edge.
REQ-029 Memory array contents SHALL NOT be affected by rst.

Structure
REQ-030 Shared package bus_pkg: FSM state constants, bus width constants (ADDR_W=32, DATA_W=32, MASK_W=4).
REQ-031 One sub-module, bus_mem_array: DEPTH_WORDS x 32 synchronous single-port array, per-byte write enable, INIT_FILE load; FSM and counter remain in bus_mem_responder.

Verification
REQ-032 LATENCY=1, write addr 0x10 data 0xDEADBEEF mask 4'b1111, then read 0x10 -> bus_done one cycle after each acceptance; rdata 0xDEADBEEF.
REQ-033 LATENCY=3, write 0x11223344 to 0x20 mask 4'b1111, then byte write addr 0x22 wdata 0x00AA0000 mask 4'b0100; read 0x20 -> done 3 cycles after acceptance; rdata 0x11AA3344.
REQ-034 Read addr 0x4000 with DEPTH_WORDS=4096 -> bus_done and bus_err pulse together; rdata 0x0; write to same address leaves in-range words unchanged.
REQ-035 LATENCY=4, write 0x55 to 0x8, rst asserted 2 cycles after acceptance -> no bus_done; later read 0x8 returns previous contents.
REQ-036 bus_wen and bus_ren both high, addr 0x30 wdata 0xCAFEF00D -> write performed, rdata unchanged; subsequent read returns 0xCAFEF00D.
REQ-037 Initiator holds bus_ren through DONE, two reads back-to-back -> exactly one done pulse per request, separated by at least one idle cycle.

Source files
------------

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus memory responder slice: bus widths, the
// one-hot FSM state type, the latency counter width and a small helper that
// gates the byte-lane mask.
// No ports (package).
// ---------------------------------------------------------------------------
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    // Word index is the byte address with the two lane bits dropped.
    localparam int WORD_W = ADDR_W - 2;

    // Wide enough for the largest reload value (LATENCY-2 with LATENCY <= 15).
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_BUSY = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    // Byte-lane enables that are active only when the write really happens.
    function automatic logic [MASK_W-1:0] gate_mask(input logic [MASK_W-1:0] mask,
                                                    input logic             en);
        return en ? mask : '0;
    endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// ---------------------------------------------------------------------------
// bus_mem_responder_if
// Request/response bundle between a bus initiator and bus_mem_responder.
// Signals:
//   bus_addr  [31:0]  byte address (word index = bus_addr[31:2])
//   bus_wdata [31:0]  lane-aligned write data
//   bus_wmask [3:0]   byte-lane write enables
//   bus_wen, bus_ren  request levels, held by the initiator until bus_done
//   bus_rdata [31:0]  registered read data
//   bus_done          one-cycle completion pulse
//   bus_err           one-cycle out-of-range pulse, coincident with bus_done
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface bus_mem_responder_if;
    import bus_pkg::*;

    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [MASK_W-1:0] bus_wmask;
    logic              bus_wen;
    logic              bus_ren;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_done;
    logic              bus_err;

    modport master (
        output bus_addr, bus_wdata, bus_wmask, bus_wen, bus_ren,
        input  bus_rdata, bus_done, bus_err
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_wmask, bus_wen, bus_ren,
        output bus_rdata, bus_done, bus_err
    );

endinterface

// File: rtl/bus_mem_array.sv
// ---------------------------------------------------------------------------
// bus_mem_array
// DEPTH_WORDS x 32 synchronous single-port memory with per-byte write enable
// and a registered read port. The read register can be cleared, which lets
// the responder use it directly as its bus_rdata output.
// Ports:
//   clk     clock
//   rd_clr  clear read register to zero (takes priority over rd_en)
//   rd_en   load read register with mem[addr]
//   wr_be   byte-lane write enables for mem[addr]
//   addr    word index
//   wdata   write data
//   rdata   registered read data
// ---------------------------------------------------------------------------
module bus_mem_array
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter     INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           rd_clr,
    input  logic                           rd_en,
    input  logic [MASK_W-1:0]              wr_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane writes; lanes without an enable keep their old contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MASK_W; i++) begin
            if (wr_be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register holds its value until the next load or clear.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// ---------------------------------------------------------------------------
// bus_mem_responder
// Memory-backed bus slave. A request (bus_wen or bus_ren level) seen in IDLE
// is accepted and completes LATENCY cycles later with a one-cycle bus_done.
// Out-of-range word indices suppress writes, return zero on reads and raise
// bus_err together with bus_done.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (memory contents are not affected)
//   bus  bus_mem_responder_if.slave request/response bundle
// ---------------------------------------------------------------------------
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic                clk,
    input  logic                rst,
    bus_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    logic [WORD_W-1:0]  lat_word;
    logic [DATA_W-1:0]  lat_wdata;
    logic [MASK_W-1:0]  lat_wmask;
    logic               lat_write;

    logic               req;
    logic               cur_write;
    logic [WORD_W-1:0]  cur_word;
    logic [DATA_W-1:0]  cur_wdata;
    logic [MASK_W-1:0]  cur_wmask;
    logic               cur_in_range;
    logic               complete;
    logic               unused_addr_lsbs;

    assign req              = bus.bus_wen | bus.bus_ren;
    assign unused_addr_lsbs = ^bus.bus_addr[1:0];

    // With LATENCY=1 the request completes on the very edge that accepts it,
    // so in IDLE the live inputs are the operands; in every other state the
    // latched copy is used, which keeps late input changes out of the request.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_write = bus.bus_wen;
            cur_word  = bus.bus_addr[ADDR_W-1:2];
            cur_wdata = bus.bus_wdata;
            cur_wmask = bus.bus_wmask;
        end else begin
            cur_write = lat_write;
            cur_word  = lat_word;
            cur_wdata = lat_wdata;
            cur_wmask = lat_wmask;
        end
    end

    assign cur_in_range = cur_word < WORD_W'(DEPTH_WORDS);

    // High when the coming edge moves the FSM into DONE; reset wins.
    always_comb begin
        complete = 1'b0;
        if (!rst) begin
            if (state == ST_IDLE) begin
                complete = req && (LATENCY == 1);
            end else if (state == ST_BUSY) begin
                complete = (cnt == '0);
            end
        end
    end

    // Main FSM with registered done/err. Data latches need no reset since
    // they are only consumed after an acceptance reloads them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bus.bus_done <= 1'b0;
            bus.bus_err  <= 1'b0;
        end else begin
            bus.bus_done <= 1'b0;
            bus.bus_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        lat_word  <= bus.bus_addr[ADDR_W-1:2];
                        lat_wdata <= bus.bus_wdata;
                        lat_wmask <= bus.bus_wmask;
                        lat_write <= bus.bus_wen;
                        if (LATENCY == 1) begin
                            state        <= ST_DONE;
                            bus.bus_done <= 1'b1;
                            bus.bus_err  <= ~cur_in_range;
                        end else begin
                            state <= ST_BUSY;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state        <= ST_DONE;
                        bus.bus_done <= 1'b1;
                        bus.bus_err  <= ~cur_in_range;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The array's read register is bus_rdata: it loads on in-range read
    // completion, clears on reset or an out-of-range read, and otherwise holds
    // (a write, including a combined write+read, leaves it untouched).
    bus_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk    (clk),
        .rd_clr (rst | (complete & ~cur_write & ~cur_in_range)),
        .rd_en  (complete & ~cur_write & cur_in_range),
        .wr_be  (gate_mask(cur_wmask, complete & cur_write & cur_in_range)),
        .addr   (cur_word[AW-1:0]),
        .wdata  (cur_wdata),
        .rdata  (bus.bus_rdata)
    );

endmodule

// File: tb/tb_bus_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_mem_responder
// Drives three responders (LATENCY 1, 3 and 4, DEPTH_WORDS 4096) from one
// shared set of stimulus signals; only the selected instance sees requests.
// ---------------------------------------------------------------------------
module tb_bus_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    int          sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        ren;

    int n_cmp = 0;
    int n_bad = 0;

    bus_mem_responder_if if0 ();
    bus_mem_responder_if if1 ();
    bus_mem_responder_if if2 ();

    assign if0.bus_addr  = addr;
    assign if0.bus_wdata = wdata;
    assign if0.bus_wmask = wmask;
    assign if0.bus_wen   = wen && (sel == 0);
    assign if0.bus_ren   = ren && (sel == 0);
    assign if1.bus_addr  = addr;
    assign if1.bus_wdata = wdata;
    assign if1.bus_wmask = wmask;
    assign if1.bus_wen   = wen && (sel == 1);
    assign if1.bus_ren   = ren && (sel == 1);
    assign if2.bus_addr  = addr;
    assign if2.bus_wdata = wdata;
    assign if2.bus_wmask = wmask;
    assign if2.bus_wen   = wen && (sel == 2);
    assign if2.bus_ren   = ren && (sel == 2);

    bus_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) u_lat1 (
        .clk (clk), .rst (rst_v[0]), .bus (if0)
    );
    bus_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(3)) u_lat3 (
        .clk (clk), .rst (rst_v[1]), .bus (if1)
    );
    bus_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(4)) u_lat4 (
        .clk (clk), .rst (rst_v[2]), .bus (if2)
    );

    logic        done_s;
    logic        err_s;
    logic [31:0] rdata_s;

    always_comb begin
        done_s  = if0.bus_done;
        err_s   = if0.bus_err;
        rdata_s = if0.bus_rdata;
        if (sel == 1) begin
            done_s  = if1.bus_done;
            err_s   = if1.bus_err;
            rdata_s = if1.bus_rdata;
        end else if (sel == 2) begin
            done_s  = if2.bus_done;
            err_s   = if2.bus_err;
            rdata_s = if2.bus_rdata;
        end
    end

    typedef struct {
        int          s;
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[20];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One request: present at a negedge, count edges until bus_done, then drop
    // the request and confirm the done pulse lasted one cycle. With mutate set,
    // address and data are disturbed right after acceptance.
    task automatic apply_stimulus(input int s, input logic w, input logic r,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] m, input logic mutate,
                                  output int cycles, output logic err_seen,
                                  output logic [31:0] rd_seen);
        logic found;
        @(negedge clk);
        sel = s; wen = w; ren = r; addr = a; wdata = d; wmask = m;
        cycles = 0; err_seen = 1'b0; rd_seen = '0; found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (done_s) begin
                found    = 1'b1;
                err_seen = err_s;
                rd_seen  = rdata_s;
                break;
            end
            if (mutate && i == 0) begin
                addr  = a ^ 32'h4;
                wdata = ~d;
            end
        end
        if (!found) cycles = 99;
        wen = 1'b0; ren = 1'b0;
        @(posedge clk); #1;
        check_output("done_pulse_width", {31'b0, done_s}, 32'h0);
    endtask

    // Hold a read request for n edges and record bus_done after each edge.
    task automatic hold_read(input int s, input logic [31:0] a, input int n,
                             output logic [15:0] pat);
        @(negedge clk);
        sel = s; wen = 1'b0; ren = 1'b1; addr = a;
        pat = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pat[i] = done_s;
        end
        ren = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          cyc;
        logic        err;
        logic [31:0] rd;
        logic [15:0] pat;
        int          done_cnt;

        vecs[0]  = '{0, 1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 4'hF, 1, 1'b0, 32'h0};
        vecs[1]  = '{0, 1'b0, 1'b1, 32'h10,       32'h0,        4'h0, 1, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{0, 1'b1, 1'b1, 32'h30,       32'hCAFEF00D, 4'hF, 1, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{0, 1'b0, 1'b1, 32'h30,       32'h0,        4'h0, 1, 1'b0, 32'hCAFEF00D};
        vecs[4]  = '{0, 1'b1, 1'b0, 32'h0,        32'h0BADC0DE, 4'hF, 1, 1'b0, 32'hCAFEF00D};
        vecs[5]  = '{0, 1'b0, 1'b1, 32'h4000,     32'h0,        4'h0, 1, 1'b1, 32'h0};
        vecs[6]  = '{0, 1'b1, 1'b0, 32'h4000,     32'hFFFFFFFF, 4'hF, 1, 1'b1, 32'h0};
        vecs[7]  = '{0, 1'b0, 1'b1, 32'h0,        32'h0,        4'h0, 1, 1'b0, 32'h0BADC0DE};
        vecs[8]  = '{0, 1'b1, 1'b0, 32'h10,       32'h12345678, 4'h0, 1, 1'b0, 32'h0BADC0DE};
        vecs[9]  = '{0, 1'b0, 1'b1, 32'h10,       32'h0,        4'h0, 1, 1'b0, 32'hDEADBEEF};
        vecs[10] = '{0, 1'b1, 1'b0, 32'h12,       32'h99887766, 4'h3, 1, 1'b0, 32'hDEADBEEF};
        vecs[11] = '{0, 1'b0, 1'b1, 32'h10,       32'h0,        4'h0, 1, 1'b0, 32'hDEAD7766};
        vecs[12] = '{1, 1'b1, 1'b0, 32'h20,       32'h11223344, 4'hF, 3, 1'b0, 32'h0};
        vecs[13] = '{1, 1'b1, 1'b0, 32'h22,       32'h00AA0000, 4'h4, 3, 1'b0, 32'h0};
        vecs[14] = '{1, 1'b0, 1'b1, 32'h20,       32'h0,        4'h0, 3, 1'b0, 32'h11AA3344};
        vecs[15] = '{1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h0,        4'h0, 3, 1'b1, 32'h0};
        vecs[16] = '{1, 1'b1, 1'b0, 32'h3FFC,     32'hA5A5A5A5, 4'hF, 3, 1'b0, 32'h0};
        vecs[17] = '{1, 1'b0, 1'b1, 32'h3FFC,     32'h0,        4'h0, 3, 1'b0, 32'hA5A5A5A5};
        vecs[18] = '{2, 1'b1, 1'b0, 32'h8,        32'h12345678, 4'hF, 4, 1'b0, 32'h0};
        vecs[19] = '{2, 1'b0, 1'b1, 32'h8,        32'h0,        4'h0, 4, 1'b0, 32'h12345678};

        sel = 0; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0; wmask = '0;
        rst_v = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_done_lat1",  {31'b0, if0.bus_done}, 32'h0);
        check_output("reset_err_lat1",   {31'b0, if0.bus_err},  32'h0);
        check_output("reset_rdata_lat1", if0.bus_rdata,         32'h0);
        check_output("reset_done_lat3",  {31'b0, if1.bus_done}, 32'h0);
        check_output("reset_err_lat3",   {31'b0, if1.bus_err},  32'h0);
        check_output("reset_rdata_lat3", if1.bus_rdata,         32'h0);
        check_output("reset_done_lat4",  {31'b0, if2.bus_done}, 32'h0);
        check_output("reset_err_lat4",   {31'b0, if2.bus_err},  32'h0);
        check_output("reset_rdata_lat4", if2.bus_rdata,         32'h0);
        @(negedge clk);
        rst_v = 3'b000;

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(vecs[i].s, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d,
                           vecs[i].m, 1'b0, cyc, err, rd);
            check_output($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].cyc));
            check_output($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
            check_output($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
        end

        // Reset two cycles into a LATENCY=4 write aborts it.
        @(negedge clk);
        sel = 2; wen = 1'b1; ren = 1'b0; addr = 32'h8; wdata = 32'h55; wmask = 4'hF;
        done_cnt = 0;
        @(posedge clk); #1;
        if (done_s) done_cnt++;
        wen = 1'b0; addr = 32'h0; wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        if (done_s) done_cnt++;
        @(negedge clk);
        rst_v[2] = 1'b1;
        @(posedge clk); #1;
        if (done_s) done_cnt++;
        @(negedge clk);
        rst_v[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done_s) done_cnt++;
        end
        check_output("abort_no_done", 32'(done_cnt), 32'h0);
        check_output("abort_rdata_reset", rdata_s, 32'h0);
        apply_stimulus(2, 1'b0, 1'b1, 32'h8, 32'h0, 4'h0, 1'b0, cyc, err, rd);
        check_output("abort_read_latency", 32'(cyc), 32'd4);
        check_output("abort_read_rdata", rd, 32'h12345678);

        // Inputs disturbed after acceptance do not affect the in-flight write.
        apply_stimulus(1, 1'b1, 1'b0, 32'h40, 32'h11111111, 4'hF, 1'b1, cyc, err, rd);
        check_output("late_change_latency", 32'(cyc), 32'd3);
        check_output("late_change_rdata", rd, 32'hA5A5A5A5);
        apply_stimulus(1, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b0, cyc, err, rd);
        check_output("late_change_read", rd, 32'h11111111);

        // Request held through DONE: one pulse per request with idle gaps.
        hold_read(0, 32'h10, 6, pat);
        check_output("b2b_lat1_pattern", {16'h0, pat}, 32'h0015);
        hold_read(1, 32'h20, 8, pat);
        check_output("b2b_lat3_pattern", {16'h0, pat}, 32'h0044);
        check_output("b2b_lat3_rdata", rdata_s, 32'h11AA3344);

        // Reset coinciding with a request wins: no accept, no write.
        @(negedge clk);
        sel = 0; wen = 1'b1; ren = 1'b0; addr = 32'h10; wdata = 32'h0; wmask = 4'hF;
        rst_v[0] = 1'b1;
        @(posedge clk); #1;
        check_output("rst_prio_done", {31'b0, done_s}, 32'h0);
        check_output("rst_prio_rdata", rdata_s, 32'h0);
        @(negedge clk);
        wen = 1'b0;
        rst_v[0] = 1'b0;
        @(posedge clk); #1;
        check_output("rst_prio_no_late_done", {31'b0, done_s}, 32'h0);
        apply_stimulus(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, cyc, err, rd);
        check_output("rst_prio_read_latency", 32'(cyc), 32'd1);
        check_output("rst_prio_read_rdata", rd, 32'hDEAD7766);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
